// File: rtl/data_mem_responder_if.sv
// Data-port bundle between the MEM pipeline stage (master) and the memory responder (slave).
interface data_mem_responder_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        err_o;

    modport master (
        output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        input  mem_data_o, stallreq_o, err_o
    );

    modport slave (
        input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
        output mem_data_o, stallreq_o, err_o
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-stated data memory responder: big-endian byte-lane writes, full-word reads, stall until done.
//
//   state  | meaning
//   S_IDLE | no access in flight; a request is latched when mem_ce_i is high
//   S_WAIT | counting down wait states on the latched request
//   S_RESP | one-cycle response; read data / err_o valid, pipeline advances
module data_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave bus
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [31:0] lat_data;
    logic [31:2] lat_addr;
    logic [31:0] data_q;
    logic        err_q;

    logic        acc_we;
    logic [3:0]  acc_sel;
    logic [31:0] acc_data;
    logic [31:2] acc_addr;
    logic [ADDR_W-1:0] acc_idx;
    logic        acc_oor;
    logic        commit;
    logic [31:0] rd_word;
    logic        unused_ofs;

    // With no wait states the commit edge is the accept edge, so use the live request there.
    assign acc_we   = (state == S_IDLE) ? bus.mem_we_i         : lat_we;
    assign acc_sel  = (state == S_IDLE) ? bus.mem_sel_i        : lat_sel;
    assign acc_data = (state == S_IDLE) ? bus.mem_data_i       : lat_data;
    assign acc_addr = (state == S_IDLE) ? bus.mem_addr_i[31:2] : lat_addr;
    assign acc_idx  = acc_addr[ADDR_W+1:2];
    assign acc_oor  = |acc_addr[31:ADDR_W+2];
    assign unused_ofs = ^bus.mem_addr_i[1:0];

    assign commit = !rst && ((NO_WAIT && state == S_IDLE && bus.mem_ce_i) ||
                             (state == S_WAIT && cnt == 4'd1));

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] ram [DEPTH];
        logic       we_lane;

        assign we_lane = commit && acc_we && !acc_oor && acc_sel[l];

        always_ff @(posedge clk) begin
            if (we_lane) begin
                ram[acc_idx] <= acc_data[8*l +: 8];
            end
        end

        assign rd_word[8*l +: 8] = ram[acc_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            lat_we   <= 1'b0;
            lat_sel  <= '0;
            lat_data <= '0;
            lat_addr <= '0;
        end else begin
            err_q <= commit && acc_oor;
            if (commit && !acc_we) begin
                data_q <= acc_oor ? 32'h0 : rd_word;
            end
            case (state)
                S_IDLE: begin
                    if (bus.mem_ce_i) begin
                        lat_we   <= bus.mem_we_i;
                        lat_sel  <= bus.mem_sel_i;
                        lat_data <= bus.mem_data_i;
                        lat_addr <= bus.mem_addr_i[31:2];
                        cnt      <= WAIT_LD;
                        state    <= NO_WAIT ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_data_o = data_q;
    assign bus.err_o      = err_q;
    assign bus.stallreq_o = !rst && ((state == S_IDLE && bus.mem_ce_i) || state == S_WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state instance (k=1) and a 0-wait-state instance (k=0)
// checked against a word-array model of big-endian byte-lane memory.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if bus2();
    data_mem_responder_if bus0();

    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl     [2][32];
    logic [31:0] last_rd [2];

    function automatic int exp_stall(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic bit is_oor(input logic [31:0] a);
        return a >= 32'h0000_1000;
    endfunction

    // Byte offset b of a big-endian word lives in bits [31-8b -: 8] and is enabled by sel[3-b].
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++)
            if (s[3-b]) w[31-8*b -: 8] = d[31-8*b -: 8];
        return w;
    endfunction

    task automatic drive(input int k, input logic ce, input logic we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (k == 1) begin
            bus2.mem_ce_i = ce; bus2.mem_we_i = we; bus2.mem_addr_i = a;
            bus2.mem_sel_i = s; bus2.mem_data_i = d;
        end else begin
            bus0.mem_ce_i = ce; bus0.mem_we_i = we; bus0.mem_addr_i = a;
            bus0.mem_sel_i = s; bus0.mem_data_i = d;
        end
    endtask

    function automatic logic get_stall(input int k);
        return (k == 1) ? bus2.stallreq_o : bus0.stallreq_o;
    endfunction

    function automatic logic [31:0] get_data(input int k);
        return (k == 1) ? bus2.mem_data_o : bus0.mem_data_o;
    endfunction

    function automatic logic get_err(input int k);
        return (k == 1) ? bus2.err_o : bus0.err_o;
    endfunction

    // Issues one request and returns at the negedge of the response cycle. Junk requests
    // are driven while the access is in flight; call quiet() unless another access follows.
    task automatic access(input int k, input logic we, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int n_stall, output logic [31:0] rdata,
                          output logic rerr);
        @(posedge clk); #1;
        drive(k, 1'b1, we, a, s, d);
        n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!get_stall(k)) break;
            n_stall++;
            @(posedge clk); #1;
            drive(k, 1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom);
        end
        rdata = get_data(k);
        rerr  = get_err(k);
    endtask

    task automatic quiet(input int k);
        drive(k, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset;
        int ns; logic [31:0] rd; logic re;
        rst = 1'b1;
        drive(1, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        drive(0, 1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus2.stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_stall_w2: got %b expected 0", bus2.stallreq_o); end
        checks++; if (bus0.stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_stall_w0: got %b expected 0", bus0.stallreq_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        quiet(1); quiet(0);
        @(negedge clk);
        checks++; if (bus2.mem_data_o !== 32'h0) begin errors++; $display("FAIL rst_data_w2: got %h expected 00000000", bus2.mem_data_o); end
        checks++; if (bus2.err_o !== 1'b0) begin errors++; $display("FAIL rst_err_w2: got %b expected 0", bus2.err_o); end
        checks++; if (bus2.stallreq_o !== 1'b0) begin errors++; $display("FAIL idle_stall_w2: got %b expected 0", bus2.stallreq_o); end
        checks++; if (bus0.mem_data_o !== 32'h0) begin errors++; $display("FAIL rst_data_w0: got %h expected 00000000", bus0.mem_data_o); end
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 32; w++) begin
                access(k, 1'b1, 32'(w * 4), 4'hF, 32'h0, ns, rd, re);
                mdl[k][w] = 32'h0;
            end
            quiet(k);
        end
    endtask

    task automatic test_first_read;
        int ns; logic [31:0] rd; logic re;
        access(1, 1'b0, 32'h0000_0010, 4'hF, 32'hA5A5_A5A5, ns, rd, re);
        quiet(1);
        checks++; if (ns != 3) begin errors++; $display("FAIL first_rd_stall: got %0d expected 3", ns); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL first_rd_data: got %h expected 00000000", rd); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL first_rd_err: got %b expected 0", re); end
        last_rd[1] = 32'h0;
    endtask

    task automatic test_word_rw;
        int ns; logic [31:0] rd; logic re;
        access(1, 1'b1, 32'h20, 4'hF, 32'hDEAD_BEEF, ns, rd, re);
        mdl[1][8] = 32'hDEAD_BEEF;
        checks++; if (ns != 3) begin errors++; $display("FAIL sw_stall: got %0d expected 3", ns); end
        checks++; if (rd !== last_rd[1]) begin errors++; $display("FAIL sw_keeps_rdata: got %h expected %h", rd, last_rd[1]); end
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, ns, rd, re);
        quiet(1);
        checks++; if (ns != 3) begin errors++; $display("FAIL lw_stall: got %0d expected 3", ns); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data: got %h expected deadbeef", rd); end
        last_rd[1] = 32'hDEAD_BEEF;
    endtask

    task automatic test_byte_store;
        int ns; logic [31:0] rd; logic re;
        access(1, 1'b1, 32'h21, 4'b0100, 32'h5555_5555, ns, rd, re);
        mdl[1][8] = merge(mdl[1][8], 32'h5555_5555, 4'b0100);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_keeps_rdata: got %h expected deadbeef", rd); end
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, ns, rd, re);
        quiet(1);
        checks++; if (rd !== 32'hDE55_BEEF) begin errors++; $display("FAIL sb_readback: got %h expected de55beef", rd); end
        last_rd[1] = rd;
        access(1, 1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, ns, rd, re);
        access(1, 1'b0, 32'h20, 4'hF, 32'h0, ns, rd, re);
        quiet(1);
        checks++; if (rd !== mdl[1][8]) begin errors++; $display("FAIL sel0_write: got %h expected %h", rd, mdl[1][8]); end
        last_rd[1] = mdl[1][8];
    endtask

    task automatic test_out_of_range;
        int ns; logic [31:0] rd; logic re;
        access(1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, ns, rd, re);
        quiet(1);
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", re); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 00000000", rd); end
        last_rd[1] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus2.err_o !== 1'b0) begin errors++; $display("FAIL oor_err_pulse: got %b expected 0", bus2.err_o); end
        access(1, 1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, ns, rd, re);
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", re); end
        access(1, 1'b0, 32'h0000_0000, 4'hF, 32'h0, ns, rd, re);
        quiet(1);
        checks++; if (rd !== mdl[1][0]) begin errors++; $display("FAIL oor_wr_no_effect: got %h expected %h", rd, mdl[1][0]); end
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL inrange_err: got %b expected 0", re); end
        last_rd[1] = mdl[1][0];
    endtask

    task automatic test_reset_abort;
        int ns; logic [31:0] rd; logic re;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h1234_5678);
        @(posedge clk); #1;
        quiet(1);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus2.stallreq_o !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected 0", bus2.stallreq_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, ns, rd, re);
        quiet(1);
        checks++; if (ns != 3) begin errors++; $display("FAIL abort_rd_stall: got %0d expected 3", ns); end
        checks++; if (rd !== mdl[1][16]) begin errors++; $display("FAIL abort_discard: got %h expected %h", rd, mdl[1][16]); end
        last_rd[1] = mdl[1][16];
    endtask

    task automatic test_zero_wait;
        int ns; logic [31:0] rd; logic re; int w; logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            w = int'($urandom_range(0, 31));
            d = $urandom;
            access(0, 1'b1, 32'(w * 4 + int'($urandom_range(0, 3))), 4'hF, d, ns, rd, re);
            mdl[0][w] = d;
            checks++; if (ns != 1) begin errors++; $display("FAIL zw_sw_stall: got %0d expected 1", ns); end
            access(0, 1'b0, 32'(w * 4), 4'hF, $urandom, ns, rd, re);
            last_rd[0] = d;
            checks++; if (ns != 1) begin errors++; $display("FAIL zw_lw_stall: got %0d expected 1", ns); end
            checks++; if (rd !== d) begin errors++; $display("FAIL zw_lw_data: got %h expected %h", rd, d); end
        end
        quiet(0);
    endtask

    task automatic test_random(input int k);
        int ns; logic [31:0] rd; logic re;
        logic we; logic oor; logic [31:0] a; logic [3:0] s; logic [31:0] d; logic [31:0] exp_d;
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom);
            oor = ($urandom_range(0, 5) == 0);
            a   = oor ? ((32'($urandom_range(1, 32'hF_FFFF)) << 12) | ($urandom & 32'hFFF))
                      : 32'($urandom_range(0, 127));
            s   = 4'($urandom);
            d   = $urandom;
            access(k, we, a, s, d, ns, rd, re);
            if (we) begin
                exp_d = last_rd[k];
                if (!is_oor(a)) mdl[k][a / 4] = merge(mdl[k][a / 4], d, s);
            end else begin
                exp_d = is_oor(a) ? 32'h0 : mdl[k][a / 4];
                last_rd[k] = exp_d;
            end
            checks++; if (ns != exp_stall(k)) begin errors++; $display("FAIL rnd_stall k=%0d op=%0d: got %0d expected %0d", k, i, ns, exp_stall(k)); end
            checks++; if (re !== is_oor(a)) begin errors++; $display("FAIL rnd_err k=%0d op=%0d addr=%h: got %b expected %b", k, i, a, re, is_oor(a)); end
            checks++; if (rd !== exp_d) begin errors++; $display("FAIL rnd_data k=%0d op=%0d addr=%h we=%b: got %h expected %h", k, i, a, we, rd, exp_d); end
            if ($urandom_range(0, 3) == 0) begin
                quiet(k);
                @(posedge clk);
            end
        end
        quiet(k);
    endtask

    initial begin
        rst = 1'b1;
        quiet(0); quiet(1);
        test_reset;
        test_first_read;
        test_word_rw;
        test_byte_store;
        test_out_of_range;
        test_reset_abort;
        test_zero_wait;
        test_random(1);
        test_random(0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the data port driven by the MEM pipeline stage.
- Accepts chip-enable, write-enable, byte-select, address and store-data requests, and performs big-endian byte-lane writes or full-word reads on an internal RAM.
- Each access takes a configurable number of wait states. It holds the pipeline with a stall request until the access completes.

Parameters:
- ADDR_W, 10: word-address width; RAM depth is 2^ADDR_W words of 32 bits.
- WAIT_CYCLES, 2: wait states per access, legal range 0..15.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset
- mem_ce_i  in  1  request valid (chip enable)
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  byte address
- mem_sel_i  in  4  byte lanes; sel[3] = bits 31:24 = byte offset 0, sel[0] = bits 7:0 = offset 3
- mem_data_i  in  32  store data, replicated across lanes by the requester for byte stores
- mem_data_o  out  32  read data returned to the MEM stage
- stallreq_o  out  1  pipeline hold request
- err_o  out  1  out-of-range access flag

Behaviour:
- Reset is rst, synchronous, active-high.
  - State returns to IDLE; wait counter is 0; mem_data_o = 0; err_o = 0.
  - stallreq_o = 0 while rst = 1.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - When mem_ce_i = 1, latch addr, we, sel and data. Counter loads WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
  - When mem_ce_i = 0, stay in IDLE.
- WAIT: counter decrements each cycle. When the counter = 1, next state is RESP.
- Commit edge (the edge entering RESP):
  - Writes: every lane with its latched sel bit set is written from the latched data; other lanes are unchanged.
  - Reads: the addressed word is registered into mem_data_o.
- RESP: lasts exactly 1 cycle, then next state is IDLE unconditionally. The pipeline advances on the edge leaving RESP.
- stallreq_o is combinational:
  - 1 when (state = IDLE and mem_ce_i = 1), or state = WAIT.
  - 0 in RESP and in idle with no request.
  - It must never depend on mem_data_o.
- Latency: a request first seen in IDLE at cycle N gets its data/commit at the edge ending cycle N+WAIT_CYCLES. RESP is cycle N+WAIT_CYCLES+1. Total occupancy is WAIT_CYCLES+2 cycles per access.
- mem_data_o holds its value until the next read commit. Writes do not change it.
- Word index is mem_addr_i[ADDR_W+1:2]. Address bits [1:0] are ignored; lane choice comes from sel only.
- Out of range (any of mem_addr_i[31:ADDR_W+2] nonzero):
  - No RAM write occurs.
  - A read loads 0 into mem_data_o.
  - err_o = 1 for the RESP cycle only; otherwise err_o = 0.
- A write with sel = 0000 completes normally with no RAM change.
- Requests arriving in WAIT or RESP are ignored. The latched request governs the access and inputs may change freely.
- Back-to-back: a new request in the cycle after RESP is accepted in IDLE with no extra bubble.
- Reset mid-access (WAIT or RESP): the FSM aborts to IDLE. A write not yet committed is discarded; an already committed write remains.
- Implementation uses an array of 4 byte-lane RAMs with one synchronous write enable per lane, and a 4-bit counter.

Test Plan:
- Reset, then a read of addr 0x0000_0010 with WAIT_CYCLES=2 -> stallreq_o high for 3 cycles. mem_data_o = 0x0000_0000 in RESP (RAM preloaded 0). err_o = 0.
- SW 0xDEADBEEF to 0x20 with sel 1111, then LW 0x20 -> mem_data_o = 0xDEADBEEF. Each access gives 4 cycles of occupancy, 3 with stallreq_o high.
- SB: data 0x55555555 to 0x21 with sel 0100 over word 0xDEADBEEF, then read 0x20 -> mem_data_o = 0xDE55BEEF.
- Read of 0x0001_0000 (ADDR_W=10) -> err_o pulses 1 in RESP, mem_data_o = 0. A write to the same address leaves RAM unchanged; verify by re-reading word 0.
- Write 0x12345678 to 0x40; assert rst during the WAIT cycle; then read 0x40 -> old contents (0) returned, stallreq_o = 0 during reset.
- WAIT_CYCLES=0 build: consecutive requests each stall exactly 1 cycle. Verify RESP→IDLE→accept with no idle gap and correct data for an alternating SW/LW sequence.
